apb_slave: RTL and testbench
============================

Name: apb_slave

Overview:
APB completer that answers the transfers issued by apb_master. It contains a word-addressed register bank of DEPTH 32-bit registers and inserts a programmable number of wait states through PREADY. Illegal addresses are flagged on PSLVERR. The block sits on the peripheral side of the APB bus, and its PREADY feeds straight back to apb_master.

Parameters:
DEPTH, 16, number of 32-bit registers; must be a power of 2, minimum 2.
WAIT_CYCLES, 1, number of access cycles with PREADY=0 before completion; range 0..15.
ADDR_W, $clog2(DEPTH), word-index width (derived; do not override).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
PSELx  input  1  slave select from master.
PENABLE  input  1  access-phase strobe from master.
PADDR  input  32  byte address.
PWDATA  input  32  write data.
PWRITE  input  1  1 = write, 0 = read.
PREADY  output  1  transfer completion (registered).
PRDATA  output  32  read data (registered); valid when PREADY=1 and PWRITE=0.
PSLVERR  output  1  error response (registered); valid only while PREADY=1.

Behaviour:
- Reset, asynchronous, active-high:
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - All registers = 0; wait counter = 0; FSM = IDLE.
  - Reset asserted mid-transfer aborts the transfer with no register write.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Setup phase (PSELx=1, PENABLE=0) sampled: load counter=WAIT_CYCLES and latch the decode result (err).
  - If WAIT_CYCLES=0, go to DONE; otherwise go to WAIT.
  - Any other input combination: stay in IDLE.
- WAIT:
  - On each edge with PSELx=1 and PENABLE=1: decrement the counter; when it goes 1->0, go to DONE.
  - PSELx=0 in WAIT (protocol abort): return to IDLE, no write, PREADY stays 0.
- DONE, entered on an edge:
  - That edge sets PREADY=1 and PSLVERR=err.
  - For a read, the same edge sets PRDATA = err ? 0 : reg[idx].
  - While in DONE, PREADY is high for exactly one cycle.
  - On the next edge: if PSELx&PENABLE&PWRITE&!err, reg[idx] <= PWDATA.
  - Also on that next edge: PREADY<=0, PSLVERR<=0, FSM -> IDLE.
  - PRDATA holds its last value until the next read completes.
- Timing: PREADY is first high in access cycle WAIT_CYCLES+1 (cycle 1 = first cycle with PENABLE=1). Total transfer = WAIT_CYCLES+2 clocks including setup.
- Back-to-back: apb_master may go ACCESS->SETUP directly with PSELx held at 1. The cycle after DONE is a setup phase, which IDLE accepts, so there are no dead cycles beyond the protocol.
- Decode:
  - idx = PADDR[ADDR_W+1:2].
  - err = (PADDR[1:0] != 0) or (PADDR[31:ADDR_W+2] != 0).
  - Decode uses the setup-phase PADDR; PADDR is stable through access per APB.
- Error transfer: a write has no effect on any register; a read returns PRDATA=0.
- Write and read to the same index in consecutive transfers: the read returns the newly written value, because the write commits before the next setup is sampled.
- PWRITE and PWDATA are sampled at commit. They equal their setup values under a compliant master.

Test Plan:
- Reset: assert reset mid-WAIT -> PREADY=0, PRDATA=0, PSLVERR=0 immediately (asynchronous); subsequent read of addr 0x4 returns 0.
- Write/read with WAIT_CYCLES=1: write 0xDEADBEEF to 0x08, then read 0x08 -> each transfer takes 3 clocks; PREADY high in access cycle 2; PRDATA=0xDEADBEEF; PSLVERR=0.
- Zero wait, WAIT_CYCLES=0: write 0x12345678 to 0x3C (idx 15), then read -> PREADY high in access cycle 1; PRDATA=0x12345678.
- Errors: write 0xFFFFFFFF to 0x40 (out of range) and to 0x05 (misaligned) -> PSLVERR=1 with PREADY. Reading 0x40 gives PRDATA=0; reading 0x04 gives its prior value, unchanged.
- Back-to-back via apb_master (transfer held high): write 0x1/0x2/0x3 to 0x0/0x4/0x8, then read all three -> correct data returned; no idle cycles between transfers.
- Abort: drop PSELx during WAIT with WAIT_CYCLES=3 -> FSM returns to IDLE, PREADY never asserts, target register unchanged.

Source files
------------

// File: rtl/apb_slave.sv
// -----------------------------------------------------------------------------
// apb_slave
//   APB completer with a word-addressed bank of DEPTH 32-bit registers.
//   A programmable number of wait states is inserted through PREADY, and
//   misaligned or out-of-range addresses complete with PSLVERR.
//
// Ports
//   clk      system clock, rising-edge active
//   reset    asynchronous, active-high reset
//   PSELx    slave select
//   PENABLE  access-phase strobe
//   PADDR    byte address (decoded in the setup phase)
//   PWDATA   write data (sampled at commit)
//   PWRITE   1 = write, 0 = read
//   PREADY   transfer completion, registered, high for one cycle
//   PRDATA   read data, registered, holds until the next read completes
//   PSLVERR  error response, registered, valid with PREADY
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no transfer; a setup phase loads the counter and the decode
//   ST_WAIT | access phase with PREADY=0, counting down the wait states
//   ST_DONE | PREADY=1 this cycle; next edge commits a write and returns idle
// -----------------------------------------------------------------------------
module apb_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              ready_d;
  logic              slverr_d;
  logic [31:0]       prdata_d;
  logic              enter_done;
  logic              wr_en;

  logic [31:0]       regs [DEPTH];

  // Address decode, only captured while a setup phase is seen in idle.
  logic [ADDR_W-1:0] dec_idx;
  logic              dec_err;

  assign dec_idx = PADDR[ADDR_W+1:2];
  assign dec_err = (PADDR[1:0] != 2'b00) || (PADDR[31:ADDR_W+2] != '0);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    idx_d      = idx_q;
    ready_d    = 1'b0;
    slverr_d   = 1'b0;
    prdata_d   = PRDATA;
    enter_done = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (PSELx && !PENABLE) begin
          cnt_d = WAIT_LD;
          err_d = dec_err;
          idx_d = dec_idx;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!PSELx) begin
          // Master abandoned the transfer: nothing is written.
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          // The <= guard keeps a corrupted zero count from wrapping to 15.
          if (cnt_q <= 4'd1) begin
            cnt_d      = 4'd0;
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      ST_DONE: begin
        // PREADY is seen by the master on this edge, so the write lands
        // before any following setup phase can be sampled.
        wr_en   = PSELx && PENABLE && PWRITE && !err_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion response is registered on the edge that enters ST_DONE.
    if (enter_done) begin
      ready_d  = 1'b1;
      slverr_d = err_d;
      if (!PWRITE) begin
        prdata_d = err_d ? 32'h0 : regs[idx_d];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      PREADY  <= ready_d;
      PSLVERR <= slverr_d;
      PRDATA  <= prdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_en) begin
      regs[idx_q] <= PWDATA;
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_slave
//   Three apb_slave instances (WAIT_CYCLES = 1, 0, 3) share the bus signals and
//   are selected one at a time. A per-instance array of register contents
//   predicts read data, error responses, latency and transfer length.
// -----------------------------------------------------------------------------
module tb_apb_slave;

  logic        clk;
  logic        reset;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        psel   [3];
  logic        ready  [3];
  logic [31:0] rdata  [3];
  logic        slverr [3];

  int          n_tests;
  int          n_fail;
  int          cyc;

  int          wc [3] = '{1, 0, 3};
  logic [31:0] model   [3][16];
  logic [31:0] last_rd [3];

  apb_slave #(.DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .PSELx(psel[0]), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PREADY(ready[0]), .PRDATA(rdata[0]), .PSLVERR(slverr[0])
  );

  apb_slave #(.DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .PSELx(psel[1]), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PREADY(ready[1]), .PRDATA(rdata[1]), .PSLVERR(slverr[1])
  );

  apb_slave #(.DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .PSELx(psel[2]), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PREADY(ready[2]), .PRDATA(rdata[2]), .PSLVERR(slverr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = 32'h0;
      for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
    end
  endtask

  // One complete transfer on instance d, entered and left #1 after an edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit keep);
    int          k;
    int          c0;
    bit          err;
    int          idx;
    logic [31:0] exp_rd;
    err = (addr[1:0] != 2'b00) || (addr[31:6] != 26'h0);
    idx = int'(addr[5:2]);
    c0  = cyc;
    for (int j = 0; j < 3; j++) if (j != d) psel[j] = 1'b0;
    psel[d] = 1'b1;
    PENABLE = 1'b0;
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    k = 1;
    while (!ready[d] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, wc[d] + 1);
    chk("pslverr", {31'h0, slverr[d]}, {31'h0, err});
    if (!wr) begin
      exp_rd = err ? 32'h0 : model[d][idx];
      chk("prdata", rdata[d], exp_rd);
      last_rd[d] = exp_rd;
    end else begin
      chk("prdata_hold", rdata[d], last_rd[d]);
    end
    @(posedge clk); #1;
    chk("ready_drop", {31'h0, ready[d]}, 32'h0);
    chk("slverr_drop", {31'h0, slverr[d]}, 32'h0);
    chk("xfer_clocks", cyc - c0, wc[d] + 2);
    if (wr && !err) model[d][idx] = wdata;
    if (!keep) begin
      psel[d] = 1'b0;
      PENABLE = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int          r;
    r = $urandom_range(0, 9);
    a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    if (r == 7) begin
      a[1:0] = 2'($urandom_range(1, 3));
    end else if (r >= 8) begin
      a = $urandom;
      if (a[31:6] == 26'h0) a[6] = 1'b1;
    end
    return a;
  endfunction

  initial begin
    int c0;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    PENABLE = 1'b0;
    PADDR   = 32'h0;
    PWDATA  = 32'h0;
    PWRITE  = 1'b0;
    for (int j = 0; j < 3; j++) psel[j] = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", {31'h0, ready[d]}, 32'h0);
      chk("rst_prdata", rdata[d], 32'h0);
      chk("rst_slverr", {31'h0, slverr[d]}, 32'h0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed: one wait state, then zero wait states.
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
    xfer(0, 1'b0, 32'h08, 32'h0, 1'b0);
    xfer(1, 1'b1, 32'h3C, 32'h12345678, 1'b0);
    xfer(1, 1'b0, 32'h3C, 32'h0, 1'b0);

    // Error responses leave the bank untouched.
    xfer(0, 1'b1, 32'h04, 32'h55AA33CC, 1'b0);
    xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 1'b0);
    xfer(0, 1'b1, 32'h05, 32'hFFFFFFFF, 1'b0);
    xfer(0, 1'b0, 32'h40, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h04, 32'h0, 1'b0);

    // Back-to-back with select held high between transfers.
    c0 = cyc;
    xfer(0, 1'b1, 32'h00, 32'h1, 1'b1);
    xfer(0, 1'b1, 32'h04, 32'h2, 1'b1);
    xfer(0, 1'b1, 32'h08, 32'h3, 1'b1);
    xfer(0, 1'b0, 32'h00, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h04, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h08, 32'h0, 1'b0);
    chk("b2b_clocks", cyc - c0, 6 * (wc[0] + 2));

    // Abort during wait states on the three-wait instance.
    xfer(2, 1'b1, 32'h10, 32'h0BADF00D, 1'b0);
    psel[2] = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'hFFFF0000;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_wait", {31'h0, ready[2]}, 32'h0);
    psel[2] = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_ready", {31'h0, ready[2]}, 32'h0);
    end
    xfer(2, 1'b0, 32'h10, 32'h0, 1'b0);

    // Randomised traffic, one instance at a time.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        xfer(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom, (n != 29) && ($urandom_range(0, 1) == 1));
      end
    end

    // Asynchronous reset in the middle of a wait phase.
    xfer(2, 1'b1, 32'h04, 32'hA5A5A5A5, 1'b0);
    xfer(2, 1'b0, 32'h04, 32'h0, 1'b0);
    psel[2] = 1'b1; PENABLE = 1'b0; PADDR = 32'h08; PWRITE = 1'b1; PWDATA = 32'h77777777;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst_ready", {31'h0, ready[2]}, 32'h0);
    chk("async_rst_prdata", rdata[2], 32'h0);
    chk("async_rst_slverr", {31'h0, slverr[2]}, 32'h0);
    psel[2] = 1'b0; PENABLE = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h04, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h08, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h04, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
